// File: rtl/lsu_pkg.sv
// Shared load/store definitions: FSM states, funct3 access codes and lane helpers.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  // Unsigned variants exist only for loads.
  function automatic logic f3_legal(input logic [2:0] f3, input logic is_store);
    case (f3)
      F3_B, F3_H, F3_W: return 1'b1;
      F3_BU, F3_HU:     return !is_store;
      default:          return 1'b0;
    endcase
  endfunction

  function automatic logic f3_aligned(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      SZ_H:    return !a[0];
      SZ_W:    return a == 2'b00;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] size_be(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      SZ_B:    return 4'b0001 << a;
      SZ_H:    return a[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] wd);
    case (f3[1:0])
      SZ_B:    return {4{wd[7:0]}};
      SZ_H:    return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

endpackage

// File: rtl/load_extend.sv
// Picks the addressed byte/halfword lane of a memory word and sign- or zero-extends it.
module load_extend
  import lsu_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] result_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata_i[{addr_lo_i, 3'b000} +: 8];
    half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (funct3_i)
      F3_B:    result_o = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    result_o = {{16{half_sel[15]}}, half_sel};
      F3_BU:   result_o = {24'h0, byte_sel};
      F3_HU:   result_o = {16'h0, half_sel};
      default: result_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one memory op at a time, issues a single-word request
// with lane-prepared data and byte enables, and returns extended load data.
//
//   state | meaning
//   IDLE  | ready; legal ops are captured, illegal ones flagged via access_err
//   REQ   | dmem_req held with the captured request until dmem_gnt
//   WAIT  | load granted; waiting for dmem_rvalid
module load_store_unit
  import lsu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        store_done,
  output logic        access_err,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata
);

  lsu_state_e  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  funct3_q, funct3_d;
  logic        store_q, store_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] load_data_q, load_data_d;
  logic        load_valid_q, load_valid_d;
  logic        store_done_q, store_done_d;
  logic        access_err_q, access_err_d;

  logic        is_mem_op;
  logic        op_legal;
  logic        accept;
  logic        reject;
  logic [31:0] ext_data;

  load_extend u_load_extend (
    .rdata_i   (dmem_rdata),
    .addr_lo_i (addr_q[1:0]),
    .funct3_i  (funct3_q),
    .result_o  (ext_data)
  );

  // Ops with neither read nor write are not memory ops and are silently dropped.
  always_comb begin
    is_mem_op = op_valid && (mem_read || mem_write);
    op_legal  = (mem_read ^ mem_write) && f3_legal(funct3, mem_write)
                && f3_aligned(funct3, addr[1:0]);
    accept    = (state_q == IDLE) && is_mem_op && op_legal;
    reject    = (state_q == IDLE) && is_mem_op && !op_legal;
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    funct3_d     = funct3_q;
    store_d      = store_q;
    be_d         = be_q;
    load_data_d  = load_data_q;
    load_valid_d = 1'b0;
    store_done_d = 1'b0;
    access_err_d = reject;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d  = REQ;
          addr_d   = addr;
          funct3_d = funct3;
          store_d  = mem_write;
          wdata_d  = store_lanes(funct3, wdata);
          be_d     = size_be(funct3, addr[1:0]);
        end
      end
      REQ: begin
        if (dmem_gnt) begin
          if (store_q) begin
            state_d      = IDLE;
            store_done_d = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (dmem_rvalid) begin
          state_d      = IDLE;
          load_valid_d = 1'b1;
          load_data_d  = ext_data;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      funct3_q     <= '0;
      store_q      <= 1'b0;
      be_q         <= '0;
      load_data_q  <= '0;
      load_valid_q <= 1'b0;
      store_done_q <= 1'b0;
      access_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      funct3_q     <= funct3_d;
      store_q      <= store_d;
      be_q         <= be_d;
      load_data_q  <= load_data_d;
      load_valid_q <= load_valid_d;
      store_done_q <= store_done_d;
      access_err_q <= access_err_d;
    end
  end

  // Request outputs decode straight from state so an async reset drops them at once.
  assign stall      = (state_q != IDLE) || accept;
  assign dmem_req   = (state_q == REQ);
  assign dmem_we    = (state_q == REQ) && store_q;
  assign dmem_addr  = {addr_q[31:2], 2'b00};
  assign dmem_wdata = wdata_q;
  assign dmem_be    = be_q;
  assign load_data  = load_data_q;
  assign load_valid = load_valid_q;
  assign store_done = store_done_q;
  assign access_err = access_err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed and randomized bench for load_store_unit against a behavioural access model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        op_valid, mem_read, mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic        stall, load_valid, store_done, access_err;
  logic [31:0] load_data;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_rdata;

  int checks = 0;
  int errors = 0;

  load_store_unit dut (
    .clk         (clk),
    .reset       (reset),
    .op_valid    (op_valid),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .funct3      (funct3),
    .addr        (addr),
    .wdata       (wdata),
    .stall       (stall),
    .load_data   (load_data),
    .load_valid  (load_valid),
    .store_done  (store_done),
    .access_err  (access_err),
    .dmem_req    (dmem_req),
    .dmem_we     (dmem_we),
    .dmem_addr   (dmem_addr),
    .dmem_wdata  (dmem_wdata),
    .dmem_be     (dmem_be),
    .dmem_gnt    (dmem_gnt),
    .dmem_rvalid (dmem_rvalid),
    .dmem_rdata  (dmem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic int model_bytes(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      3'b010:         return 4;
      default:        return 0;
    endcase
  endfunction

  function automatic bit model_legal(input logic r, input logic w, input logic [2:0] f3,
                                     input logic [1:0] off);
    int n;
    n = model_bytes(f3);
    if (r == w) return 1'b0;
    if (n == 0) return 1'b0;
    if (w && f3[2]) return 1'b0;
    return (int'(off) % n) == 0;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] word);
    logic [31:0] s;
    s = word >> (8 * int'(off));
    case (f3)
      3'b000:  return {{24{s[7]}}, s[7:0]};
      3'b001:  return {{16{s[15]}}, s[15:0]};
      3'b100:  return s & 32'h0000_00FF;
      3'b101:  return s & 32'h0000_FFFF;
      default: return word;
    endcase
  endfunction

  function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [1:0] off);
    int n;
    n = model_bytes(f3);
    return 4'(((1 << n) - 1) << int'(off));
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] wd);
    case (model_bytes(f3))
      1:       return (wd & 32'hFF) * 32'h0101_0101;
      2:       return (wd & 32'hFFFF) * 32'h0001_0001;
      default: return wd;
    endcase
  endfunction

  // Legal op: accept cycle, gnt_wait idle REQ cycles, then (loads) rv_wait WAIT cycles before rvalid.
  task automatic run_op(input bit is_load, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] rd,
                        input int gnt_wait, input int rv_wait);
    @(negedge clk);
    op_valid = 1'b1; mem_read = is_load; mem_write = !is_load;
    funct3 = f3; addr = a; wdata = wd;
    #1;
    check("stall_accept", 32'(stall), 32'd1);
    check("req_in_accept", 32'(dmem_req), 32'd0);
    for (int i = 0; i <= gnt_wait; i++) begin
      @(negedge clk);
      op_valid = 1'b0;
      dmem_rvalid = 1'b1;
      dmem_rdata = ~rd;
      dmem_gnt = (i == gnt_wait);
      #1;
      check("req_held", 32'(dmem_req), 32'd1);
      check("we_held", 32'(dmem_we), 32'(!is_load));
      check("addr_held", dmem_addr, {a[31:2], 2'b00});
      check("stall_req", 32'(stall), 32'd1);
      if (!is_load) begin
        check("be_held", 32'(dmem_be), 32'(model_be(f3, a[1:0])));
        check("wdata_held", dmem_wdata, model_wdata(f3, wd));
      end
    end
    @(negedge clk);
    dmem_gnt = 1'b0;
    dmem_rvalid = 1'b0;
    if (!is_load) begin
      #1;
      check("store_done_pulse", 32'(store_done), 32'd1);
      check("req_after_store", 32'(dmem_req), 32'd0);
      check("stall_after_store", 32'(stall), 32'd0);
      check("no_load_valid_store", 32'(load_valid), 32'd0);
      @(negedge clk); #1;
      check("store_done_width", 32'(store_done), 32'd0);
    end else begin
      for (int i = 0; i <= rv_wait; i++) begin
        if (i > 0) @(negedge clk);
        op_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0;
        funct3 = 3'b010; addr = 32'h1;
        dmem_rvalid = (i == rv_wait);
        dmem_rdata = (i == rv_wait) ? rd : ~rd;
        #1;
        check("req_in_wait", 32'(dmem_req), 32'd0);
        check("stall_wait", 32'(stall), 32'd1);
        check("no_early_load_valid", 32'(load_valid), 32'd0);
        check("no_err_busy", 32'(access_err), 32'd0);
      end
      @(negedge clk);
      op_valid = 1'b0;
      dmem_rvalid = 1'b0;
      #1;
      check("load_valid_pulse", 32'(load_valid), 32'd1);
      check("load_data", load_data, model_load(f3, a[1:0], rd));
      check("stall_after_load", 32'(stall), 32'd0);
      check("no_err_after_load", 32'(access_err), 32'd0);
      @(negedge clk); #1;
      check("load_valid_width", 32'(load_valid), 32'd0);
    end
  endtask

  // Rejected or ignored op: no request ever, access_err pulses only when expected.
  task automatic run_bad(input logic r, input logic w, input logic [2:0] f3,
                         input logic [31:0] a, input bit expect_err);
    @(negedge clk);
    op_valid = 1'b1; mem_read = r; mem_write = w; funct3 = f3; addr = a;
    #1;
    check("stall_bad", 32'(stall), 32'd0);
    check("req_bad", 32'(dmem_req), 32'd0);
    @(negedge clk);
    op_valid = 1'b0;
    #1;
    check("access_err_pulse", 32'(access_err), 32'(expect_err));
    check("req_bad_next", 32'(dmem_req), 32'd0);
    check("stall_bad_next", 32'(stall), 32'd0);
    @(negedge clk); #1;
    check("access_err_width", 32'(access_err), 32'd0);
    check("req_bad_after", 32'(dmem_req), 32'd0);
  endtask

  initial begin
    logic [2:0]  f3;
    logic [31:0] a, wd, rd;
    logic        r, w;
    int          kind;

    reset = 1'b1;
    op_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    funct3 = 3'b0; addr = 32'h0; wdata = 32'h0;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_req", 32'(dmem_req), 32'd0);
    check("rst_we", 32'(dmem_we), 32'd0);
    check("rst_load_valid", 32'(load_valid), 32'd0);
    check("rst_store_done", 32'(store_done), 32'd0);
    check("rst_access_err", 32'(access_err), 32'd0);
    check("rst_load_data", load_data, 32'd0);
    check("rst_be", 32'(dmem_be), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    run_op(1'b1, 3'b010, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 0, 1);
    run_op(1'b1, 3'b000, 32'h0000_0103, 32'h0, 32'h8011_2233, 0, 0);
    run_op(1'b1, 3'b100, 32'h0000_0103, 32'h0, 32'h8011_2233, 1, 0);
    run_op(1'b0, 3'b001, 32'h0000_0202, 32'h0000_ABCD, 32'h0, 3, 0);
    run_op(1'b0, 3'b000, 32'h0000_0301, 32'h1234_5678, 32'h0, 0, 0);
    run_op(1'b0, 3'b010, 32'h0000_0404, 32'hCAFE_F00D, 32'h0, 1, 0);
    run_op(1'b1, 3'b101, 32'h0000_0502, 32'h0, 32'h9ABC_1234, 0, 2);
    run_op(1'b1, 3'b001, 32'h0000_0502, 32'h0, 32'h9ABC_1234, 2, 1);

    run_bad(1'b1, 1'b0, 3'b010, 32'h0000_0101, 1'b1);
    run_bad(1'b0, 1'b1, 3'b001, 32'h0000_0203, 1'b1);
    run_bad(1'b0, 1'b1, 3'b100, 32'h0000_0200, 1'b1);
    run_bad(1'b1, 1'b1, 3'b010, 32'h0000_0200, 1'b1);
    run_bad(1'b1, 1'b0, 3'b011, 32'h0000_0200, 1'b1);
    run_bad(1'b0, 1'b0, 3'b010, 32'h0000_0200, 1'b0);

    // Reset in the middle of a request, then in the middle of a load wait.
    @(negedge clk);
    op_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'b010; addr = 32'h0000_0600;
    @(negedge clk);
    op_valid = 1'b0;
    #1;
    check("req_before_reset", 32'(dmem_req), 32'd1);
    reset = 1'b1;
    #1;
    check("req_dropped_reset", 32'(dmem_req), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    @(negedge clk);
    op_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'b010; addr = 32'h0000_0700;
    @(negedge clk);
    op_valid = 1'b0; dmem_gnt = 1'b1;
    @(negedge clk);
    dmem_gnt = 1'b0;
    #1;
    check("wait_stall", 32'(stall), 32'd1);
    reset = 1'b1;
    #1;
    check("wait_reset_req", 32'(dmem_req), 32'd0);
    check("wait_reset_stall", 32'(stall), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    dmem_rvalid = 1'b1; dmem_rdata = 32'h1111_2222;
    @(negedge clk);
    dmem_rvalid = 1'b0;
    #1;
    check("aborted_no_load_valid", 32'(load_valid), 32'd0);
    check("aborted_req", 32'(dmem_req), 32'd0);
    run_op(1'b1, 3'b010, 32'h0000_0800, 32'h0, 32'h0BAD_CAFE, 0, 0);

    for (int n = 0; n < 60; n++) begin
      f3 = 3'($urandom_range(0, 7));
      a = $urandom();
      wd = $urandom();
      rd = $urandom();
      kind = $urandom_range(0, 9);
      r = (kind == 1) || (kind >= 2 && kind[0]);
      w = (kind == 1) || (kind >= 2 && !kind[0]);
      if (!r && !w)
        run_bad(r, w, f3, a, 1'b0);
      else if (!model_legal(r, w, f3, a[1:0]))
        run_bad(r, w, f3, a, 1'b1);
      else
        run_op(r, f3, a, wd, rd, $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed at 32-bit data and address.
REQ-002 clk  input  1  clock; all state updates on the rising edge.
REQ-003 reset  input  1  reset, asynchronous, active-high.
REQ-004 op_valid  input  1  a memory operation is presented this cycle.
REQ-005 mem_read  input  1  the operation is a load.
REQ-006 mem_write  input  1  the operation is a store.
REQ-007 funct3  input  3  access size and sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 addr  input  32  byte address (ALU result).
REQ-009 wdata  input  32  store data (rs2 value).
REQ-010 stall  output  1  the unit is busy; upstream holds its inputs.
REQ-011 load_data  output  32  extended load result.
REQ-012 load_valid  output  1  one-cycle pulse; load_data is valid.
REQ-013 store_done  output  1  one-cycle pulse; a store was accepted by memory.
REQ-014 access_err  output  1  one-cycle pulse; misaligned access, illegal funct3 or read and write both set.
REQ-015 dmem_req, dmem_we  output  1  memory request and write enable.
REQ-016 dmem_addr  output  32  word-aligned address, {addr[31:2],2'b00}.
REQ-017 dmem_wdata  output  32  lane-replicated store data.
REQ-018 dmem_be  output  4  byte enables.
REQ-019 dmem_gnt, dmem_rvalid  input  1  memory grant and read-data valid.
REQ-020 dmem_rdata  input  32  memory read word.

Function
REQ-021 FSM states SHALL be IDLE, REQ and WAIT.
- IDLE->REQ on op_valid with exactly one of mem_read or mem_write set and a legal, aligned access.
- Address, funct3, type and prepared store lanes are captured at that transition.
REQ-022 In IDLE, an op_valid with an illegal or misaligned access SHALL pulse access_err on the next cycle, issue no memory request and stay in IDLE.
- Misaligned means W with addr[1:0]!=0, or H/HU with addr[0]!=0.
- BU/HU stores are illegal.
REQ-023 An op_valid with neither mem_read nor mem_write SHALL be ignored.
REQ-024 In REQ, dmem_req SHALL be 1 and the captured request SHALL be held stable until dmem_gnt.
- On gnt, a store returns to IDLE and pulses store_done on the next cycle.
- On gnt, a load goes to WAIT.
REQ-025 In WAIT, dmem_req SHALL be 0; on dmem_rvalid the unit returns to IDLE and drives load_valid with registered load_data on the next cycle.
- dmem_rvalid outside WAIT SHALL be ignored.
REQ-026 Load extraction SHALL select the byte or halfword lane by captured addr[1:0].
- B/H sign-extend; BU/HU zero-extend; W passes through.
REQ-027 Store lanes SHALL be:
- SB: wdata {4{wdata[7:0]}}, be = 0001 << addr[1:0].
- SH: wdata {2{wdata[15:0]}}, be = 0011 or 1100 by addr[1].
- SW: wdata as is, be = 1111.
REQ-028 stall SHALL be combinational: high whenever the state is not IDLE, and also in IDLE while a legal op_valid is being accepted.
- New ops SHALL be ignored while not in IDLE.
REQ-029 Minimum latency SHALL be:
- store: accept cycle + 1 REQ cycle, with store_done in the following cycle.
- load: accept + REQ + WAIT, with load_valid one cycle after rvalid.

Reset
REQ-030 Reset SHALL force IDLE and clear the captured registers.
- Outputs go to 0: dmem_req, dmem_we, load_valid, store_done, access_err, load_data, dmem_be.
REQ-031 Reset asserted mid-REQ or mid-WAIT SHALL drop dmem_req immediately, and any later rvalid for the aborted load SHALL be ignored.

Structure
REQ-032 Package lsu_pkg SHALL hold the state enum (IDLE, REQ, WAIT) and the funct3 size constants; ALU and decode blocks reuse the constants.
REQ-033 Load lane selection and extension SHALL be a combinational sub-module, load_extend (inputs rdata, addr[1:0], funct3; output 32-bit result).

Verification
REQ-034 LW at addr 0x100, gnt in the first REQ cycle, rdata 0xDEADBEEF two cycles later -> load_valid is one cycle wide with 0xDEADBEEF, and stall is high throughout.
REQ-035 LB and LBU at addr 0x103 with rdata 0x80112233 -> 0xFFFFFF80 and 0x00000080 respectively.
REQ-036 SH at 0x202 with wdata 0x0000ABCD -> dmem_addr 0x200, dmem_be 1100, dmem_wdata 0xABCDABCD; gnt withheld for 3 cycles with request held stable, then store_done pulses.
REQ-037 LW at 0x101 and SH at 0x203 -> access_err pulse, dmem_req never asserted, state stays IDLE.
REQ-038 Reset asserted during WAIT, then rvalid -> no load_valid, dmem_req 0, next LW completes normally.
